mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one shared memory port,
// alternating priority on contention and aborting transfers that never acknowledge.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        m_req,
   output logic        m_write,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack_n,
   output logic        busy,
   output logic        err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] D_XFER = 2'd1;
   localparam logic [1:0] I_XFER = 2'd2;

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]    state;
   logic          last_d;
   logic [CW-1:0] cnt;
   logic [31:0]   l_addr;
   logic [31:0]   l_wdata;
   logic          l_write;
   logic [1:0]    l_size;
   logic          d_elig;
   logic          i_elig;
   logic          grant_d;
   logic          grant_i;
   logic          timeout_hit;

   // A requester whose done pulse is showing is still holding req from the
   // finished transfer, so it must not be granted again this cycle.
   always_comb begin
      d_elig      = d_req & ~d_done;
      i_elig      = i_req & ~i_done;
      grant_d     = d_elig & (~i_elig | ~last_d);
      grant_i     = i_elig & ~grant_d;
      timeout_hit = (cnt == CW'(TIMEOUT - 1));
   end

   always_comb begin
      m_req   = (state != IDLE);
      busy    = m_req;
      m_write = m_req & l_write;
      m_size  = m_req ? l_size  : '0;
      m_addr  = m_req ? l_addr  : '0;
      m_wdata = m_req ? l_wdata : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         last_d  <= 1'b0;
         cnt     <= '0;
         l_addr  <= '0;
         l_wdata <= '0;
         l_write <= 1'b0;
         l_size  <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         err     <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_d) begin
                  state   <= D_XFER;
                  last_d  <= 1'b1;
                  l_addr  <= d_addr;
                  l_write <= d_write;
                  l_size  <= d_size;
                  l_wdata <= d_write ? d_wdata : '0;
               end else if (grant_i) begin
                  state   <= I_XFER;
                  last_d  <= 1'b0;
                  l_addr  <= i_addr;
                  l_write <= 1'b0;
                  l_size  <= 2'b10;
                  l_wdata <= '0;
               end
            end
            D_XFER, I_XFER: begin
               if (!m_ack_n) begin
                  state <= IDLE;
                  if (state == D_XFER) begin
                     d_done <= 1'b1;
                     if (!l_write) d_rdata <= m_rdata;
                  end else begin
                     i_done  <= 1'b1;
                     i_rdata <= m_rdata;
                  end
               end else if (timeout_hit) begin
                  state <= IDLE;
                  err   <= 1'b1;
                  if (state == D_XFER) begin
                     d_done  <= 1'b1;
                     d_rdata <= '0;
                  end else begin
                     i_done  <= 1'b1;
                     i_rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int unsigned TO = 16;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        m_req;
   logic        m_write;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack_n;
   logic        busy;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
      .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the port, what was latched, how long it has waited.
   int          e_owner;   // 0 none, 1 data, 2 fetch
   bit          e_last_d;
   int          e_wait;
   logic [31:0] e_addr;
   logic [31:0] e_wdata;
   logic        e_write;
   logic [1:0]  e_size;
   logic        e_i_done;
   logic        e_d_done;
   logic        e_err;
   logic [31:0] e_i_rdata;
   logic [31:0] e_d_rdata;
   bit          m_d_ok;
   bit          m_i_ok;
   int          m_pick;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_owner = 0; e_last_d = 0; e_wait = 0;
         e_addr = '0; e_wdata = '0; e_write = 0; e_size = '0;
         e_i_done = 0; e_d_done = 0; e_err = 0;
         e_i_rdata = '0; e_d_rdata = '0;
      end else begin
         m_d_ok = d_req && !e_d_done;
         m_i_ok = i_req && !e_i_done;
         e_i_done = 0; e_d_done = 0; e_err = 0;
         if (e_owner == 0) begin
            m_pick = 0;
            if (m_d_ok && m_i_ok) m_pick = e_last_d ? 2 : 1;
            else if (m_d_ok)      m_pick = 1;
            else if (m_i_ok)      m_pick = 2;
            if (m_pick == 1) begin
               e_owner = 1; e_last_d = 1; e_wait = 0;
               e_addr = d_addr; e_write = d_write; e_size = d_size;
               e_wdata = d_write ? d_wdata : 32'h0;
            end else if (m_pick == 2) begin
               e_owner = 2; e_last_d = 0; e_wait = 0;
               e_addr = i_addr; e_write = 0; e_size = 2'b10; e_wdata = 32'h0;
            end
         end else begin
            e_wait++;
            if (!m_ack_n) begin
               if (e_owner == 1) begin
                  e_d_done = 1;
                  if (!e_write) e_d_rdata = m_rdata;
               end else begin
                  e_i_done = 1;
                  e_i_rdata = m_rdata;
               end
               e_owner = 0;
            end else if (e_wait == TO) begin
               e_err = 1;
               if (e_owner == 1) begin e_d_done = 1; e_d_rdata = '0; end
               else begin e_i_done = 1; e_i_rdata = '0; end
               e_owner = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("m_req",   m_req,   e_owner != 0);
      chk("busy",    busy,    e_owner != 0);
      chk("m_write", m_write, (e_owner != 0) && e_write);
      chk("m_size",  m_size,  (e_owner != 0) ? e_size  : 2'b00);
      chk("m_addr",  m_addr,  (e_owner != 0) ? e_addr  : 32'h0);
      chk("m_wdata", m_wdata, (e_owner != 0) ? e_wdata : 32'h0);
      chk("i_done",  i_done,  e_i_done);
      chk("d_done",  d_done,  e_d_done);
      chk("err",     err,     e_err);
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("done_overlap", i_done & d_done, 1'b0);
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   int stall;
   int rst_hold;

   initial begin
      rst = 0; i_req = 0; i_addr = '0; d_req = 0; d_write = 0; d_size = '0;
      d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1;
      stall = 0; rst_hold = 0;
      tick; tick;
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_err", err, 1'b0);
      rst = 1;

      // single load, ack after two waiting cycles
      d_req = 1; d_write = 0; d_size = 2'b10; d_addr = 32'h0000_0100; d_wdata = 32'h1111_1111;
      tick;
      chk("ld_m_req", m_req, 1'b1);
      chk("ld_m_write", m_write, 1'b0);
      chk("ld_m_addr", m_addr, 32'h0000_0100);
      chk("ld_m_wdata", m_wdata, 32'h0);
      tick; tick;
      m_ack_n = 0; m_rdata = 32'h1234_5678;
      tick;
      chk("ld_d_done", d_done, 1'b1);
      chk("ld_d_rdata", d_rdata, 32'h1234_5678);
      chk("ld_model_d_rdata", e_d_rdata, 32'h1234_5678);
      chk("ld_err", err, 1'b0);
      chk("ld_m_req_low", m_req, 1'b0);
      d_req = 0; m_ack_n = 1;
      tick;
      chk("ld_d_done_pulse", d_done, 1'b0);

      // simultaneous requests right after reset: data first
      rst = 0; tick; rst = 1;
      i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300; m_ack_n = 0; m_rdata = 32'h22;
      tick;
      chk("both_first_addr", m_addr, 32'h300);
      tick;
      chk("both_d_done", d_done, 1'b1);
      chk("both_i_idle", i_done, 1'b0);
      chk("both_d_rdata", d_rdata, 32'h22);
      d_req = 0;
      tick;
      chk("both_second_addr", m_addr, 32'h200);
      chk("both_i_size", m_size, 2'b10);
      tick;
      chk("both_i_done", i_done, 1'b1);
      chk("both_d_quiet", d_done, 1'b0);
      i_req = 0;
      tick;

      // continuous contention alternates D,I,D,I
      d_req = 1; i_req = 1; d_addr = 32'hD00; i_addr = 32'h100; m_rdata = 32'hAAAA_0001; m_ack_n = 0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k % 2 == 1) begin
            chk("alt_m_req", m_req, 1'b1);
            chk("alt_m_addr", m_addr, (k % 4 == 1) ? 32'hD00 : 32'h100);
         end else begin
            chk("alt_d_done", d_done, k % 4 == 2);
            chk("alt_i_done", i_done, k % 4 == 0);
         end
      end
      d_req = 0; i_req = 0; m_ack_n = 1;
      tick;

      // store, with requester-side changes mid-transfer
      d_req = 1; d_write = 1; d_size = 2'b01; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D;
      m_rdata = 32'h5555_5555;
      tick;
      chk("st_m_write", m_write, 1'b1);
      chk("st_m_size", m_size, 2'b01);
      chk("st_m_wdata", m_wdata, 32'hCAFE_F00D);
      d_wdata = 32'h0; d_size = 2'b11;
      tick;
      chk("st_latched_wdata", m_wdata, 32'hCAFE_F00D);
      chk("st_latched_size", m_size, 2'b01);
      m_ack_n = 0;
      tick;
      chk("st_d_done", d_done, 1'b1);
      chk("st_d_rdata_kept", d_rdata, 32'hAAAA_0001);
      d_req = 0; d_write = 0; m_ack_n = 1;
      tick;

      // fetch that never gets acknowledged
      i_req = 1; i_addr = 32'h500;
      tick;
      chk("to_m_req", m_req, 1'b1);
      for (int k = 1; k <= 15; k++) tick;
      chk("to_not_yet", i_done, 1'b0);
      chk("to_still_req", m_req, 1'b1);
      tick;
      chk("to_i_done", i_done, 1'b1);
      chk("to_err", err, 1'b1);
      chk("to_i_rdata", i_rdata, 32'h0);
      chk("to_m_req_low", m_req, 1'b0);
      i_req = 0;
      tick;
      chk("to_err_pulse", err, 1'b0);

      // reset in the middle of a data transfer
      d_req = 1; d_write = 0; d_addr = 32'h600;
      tick;
      chk("rx_m_req", m_req, 1'b1);
      #1 rst = 0;
      #1 chk("rx_m_req_async", m_req, 1'b0);
      tick;
      chk("rx_no_done", d_done, 1'b0);
      chk("rx_d_rdata", d_rdata, 32'h0);
      rst = 1;
      tick;
      chk("rx_regrant", m_addr, 32'h600);
      m_ack_n = 0; m_rdata = 32'h6006_6006;
      tick;
      chk("rx_d_done", d_done, 1'b1);
      chk("rx_d_rdata_new", d_rdata, 32'h6006_6006);
      d_req = 0; m_ack_n = 1;
      tick;

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (!d_req) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req = 1; d_write = 1'($urandom_range(0, 1)); d_size = 2'($urandom);
               d_addr = $urandom; d_wdata = $urandom;
            end
         end else if (e_d_done) begin
            if ($urandom_range(0, 1) == 0) d_req = 0;
            else begin
               d_write = 1'($urandom_range(0, 1)); d_size = 2'($urandom);
               d_addr = $urandom; d_wdata = $urandom;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            d_addr = $urandom; d_wdata = $urandom;
         end
         if (!i_req) begin
            if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
         end else if (e_i_done) begin
            if ($urandom_range(0, 1) == 0) i_req = 0;
            else i_addr = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            i_addr = $urandom;
         end
         if (stall > 0) begin
            stall--; m_ack_n = 1;
         end else begin
            m_ack_n = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) stall = $urandom_range(10, 20);
         end
         m_rdata = $urandom;
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 0; rst_hold = 2;
         end
         tick;
      end
      rst = 1;
      tick;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
